// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM state encoding for the serial sequence detector.
package seq_det_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    RUN  = 2'b10
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit counter that saturates at all-ones; clr wins over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (clr) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: Mealy serial pattern detector, MSB of pattern received first.
// Optional match counter (cnt_clr/match_cnt) enabled by SEQ_DET_MATCH_CNT_EN.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap_en,
  input  logic             ain_valid,
  input  logic             ain,
`ifdef SEQ_DET_MATCH_CNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt,
`endif
  output logic             yout,
  output logic             yout_q,
  output logic             busy
);
  localparam int HW = PAT_W - 1;
  localparam int FW = $clog2(PAT_W);
  localparam logic [FW-1:0] FULL = FW'(PAT_W - 1);
  state_t           state, state_n;
  logic [HW-1:0]    hist, hist_n;
  logic [FW-1:0]    fill, fill_n;
  logic [PAT_W-1:0] pat_q, pat_n, window;
  logic             ov_q, ov_n, accept;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= IDLE;
      hist   <= '0;
      fill   <= '0;
      pat_q  <= '0;
      ov_q   <= 1'b0;
      yout_q <= 1'b0;
    end else begin
      state  <= state_n;
      hist   <= hist_n;
      fill   <= fill_n;
      pat_q  <= pat_n;
      ov_q   <= ov_n;
      yout_q <= yout;
    end
  // cfg_load discards any simultaneous bit; a non-overlapping match restarts the fill
  always_comb begin
    window  = {hist, ain};
    accept  = ain_valid && !cfg_load && state != IDLE;
    yout    = accept && state == RUN && window == pat_q;
    busy    = state == FILL;
    state_n = state;
    hist_n  = hist;
    fill_n  = fill;
    pat_n   = pat_q;
    ov_n    = ov_q;
    if (cfg_load) begin
      pat_n   = pattern;
      ov_n    = overlap_en;
      hist_n  = '0;
      fill_n  = '0;
      state_n = FILL;
    end else if (yout && !ov_q) begin
      hist_n  = '0;
      fill_n  = '0;
      state_n = FILL;
    end else if (accept) begin
      hist_n  = window[HW-1:0];
      fill_n  = fill == FULL ? fill : fill + 1'b1;
      state_n = fill_n == FULL ? RUN : FILL;
    end
  end
`ifdef SEQ_DET_MATCH_CNT_EN
  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (yout),
    .clr  (cnt_clr),
    .count(match_cnt)
  );
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: scoreboard bench; expected yout per driven cycle is queued and checked at negedge.
module tb_seq_detector_param;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_load = 1'b0;
  logic [3:0] pattern = '0;
  logic       overlap_en = 1'b0;
  logic       ain_valid = 1'b0;
  logic       ain = 1'b0;
  logic       yout, yout_q, busy;
  logic       exp_q[$];
  logic       prev_y = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;
`ifdef SEQ_DET_MATCH_CNT_EN
  logic       cnt_clr = 1'b0;
  logic [1:0] match_cnt;
`endif

  seq_detector_param #(.PAT_W(4), .CNT_W(2)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .cfg_load  (cfg_load),
    .pattern   (pattern),
    .overlap_en(overlap_en),
    .ain_valid (ain_valid),
    .ain       (ain),
`ifdef SEQ_DET_MATCH_CNT_EN
    .cnt_clr   (cnt_clr),
    .match_cnt (match_cnt),
`endif
    .yout      (yout),
    .yout_q    (yout_q),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic ey;
    ey = exp_q.size() != 0 ? exp_q.pop_front() : 1'b0;
    check("yout", {31'b0, yout}, {31'b0, ey});
    check("yout_q", {31'b0, yout_q}, {31'b0, rst_n ? prev_y : 1'b0});
    prev_y = rst_n ? ey : 1'b0;
  end

  task automatic drive(input logic v, input logic a, input logic ld, input logic [3:0] p,
                       input logic ov, input logic ey);
    ain_valid = v;
    ain = a;
    cfg_load = ld;
    pattern = p;
    overlap_en = ov;
    exp_q.push_back(ey);
    @(posedge clk);
    #1;
    ain_valid = 1'b0;
    cfg_load = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] p, input logic ov);
    drive(1'b0, 1'b0, 1'b1, p, ov, 1'b0);
  endtask

  task automatic bits(input int n, input logic [15:0] seq, input logic [15:0] ey);
    for (int i = n - 1; i >= 0; i--) drive(1'b1, seq[i], 1'b0, pattern, overlap_en, ey[i]);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_yout_q", {31'b0, yout_q}, 0);
`ifdef SEQ_DET_MATCH_CNT_EN
    check("rst_cnt", {30'b0, match_cnt}, 0);
`endif
    rst_n = 1'b1;
    // unprogrammed block ignores data
    bits(4, 16'b1101, 16'b0000);
    check("idle_busy", {31'b0, busy}, 0);
    // overlapping detection
    cfg(4'b1101, 1'b1);
    check("cfg_busy", {31'b0, busy}, 1);
    bits(4, 16'b1101, 16'b0001);
    check("ov_run_busy", {31'b0, busy}, 0);
    bits(3, 16'b101, 16'b001);
    // non-overlapping detection
    cfg(4'b1101, 1'b0);
    bits(4, 16'b1101, 16'b0001);
    check("nov_busy", {31'b0, busy}, 1);
    bits(3, 16'b101, 16'b000);
    // gaps hold history and mask yout even when ain would complete the pattern
    cfg(4'b1101, 1'b1);
    bits(3, 16'b110, 16'b000);
    repeat (3) drive(1'b0, 1'b1, 1'b0, pattern, overlap_en, 1'b0);
    bits(1, 16'b1, 16'b1);
    // reset mid-sequence, no reload afterwards
    cfg(4'b1101, 1'b1);
    bits(3, 16'b110, 16'b000);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", {31'b0, busy}, 0);
    rst_n = 1'b1;
    bits(5, 16'b11101, 16'b00000);
    check("post_rst_busy", {31'b0, busy}, 0);
    // cfg_load beats a completing bit
    cfg(4'b1101, 1'b1);
    bits(3, 16'b110, 16'b000);
    drive(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0);
    check("reload_busy", {31'b0, busy}, 1);
    bits(4, 16'b0110, 16'b0001);
`ifdef SEQ_DET_MATCH_CNT_EN
    cnt_clr = 1'b1;
    drive(1'b0, 1'b0, 1'b0, pattern, overlap_en, 1'b0);
    cnt_clr = 1'b0;
    check("cnt_clr", {30'b0, match_cnt}, 0);
    cfg(4'b1111, 1'b1);
    bits(8, 16'hFF, 16'b00011111);
    check("cnt_sat", {30'b0, match_cnt}, 3);
    cfg(4'b1111, 1'b1);
    check("cnt_cfg_keep", {30'b0, match_cnt}, 3);
    bits(3, 16'b111, 16'b000);
    cnt_clr = 1'b1;
    bits(1, 16'b1, 16'b1);
    cnt_clr = 1'b0;
    check("cnt_clr_win", {30'b0, match_cnt}, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits (2..16).
REQ-002 SHALL have parameter CNT_W, default 8, match-counter width.
REQ-003 SHALL have port clk, input, 1, single clock, all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port cfg_load, input, 1, strobe that latches pattern and overlap_en.
REQ-006 SHALL have port pattern, input, PAT_W, target sequence; bit PAT_W-1 is the first bit received.
REQ-007 SHALL have port overlap_en, input, 1, 1 = overlapping detection, 0 = non-overlapping.
REQ-008 SHALL have port ain_valid, input, 1, qualifies ain for the current cycle.
REQ-009 SHALL have port ain, input, 1, serial data bit.
REQ-010 SHALL have port yout, output, 1, Mealy match (combinational, same cycle as the last pattern bit).
REQ-011 SHALL have port yout_q, output, 1, registered copy of yout, one cycle later.
REQ-012 SHALL have port busy, output, 1, high while in state FILL.

Function
REQ-013 SHALL implement FSM states IDLE (unprogrammed), FILL (fewer than PAT_W-1 valid history bits), RUN (history full).
REQ-014 IDLE SHALL go to FILL on cfg_load; ain is ignored and yout stays 0 in IDLE.
REQ-015 SHALL keep a PAT_W-1 bit history shift register and a fill counter; each accepted bit (ain_valid=1) shifts in at the LSB and increments fill.
REQ-016 FILL SHALL go to RUN when fill reaches PAT_W-1.
REQ-017 yout SHALL equal ain_valid AND state==RUN AND {history, ain}==stored pattern.
REQ-018 On a match with overlap_en latched 1, history SHALL shift normally and the state stays RUN.
REQ-019 On a match with overlap_en latched 0, fill SHALL clear and the state SHALL go to FILL, so no bit of a match is reused.
REQ-020 ain_valid=0 SHALL hold history, fill and state, and force yout=0.
REQ-021 cfg_load in any state SHALL latch the new configuration, clear history and fill, and go to FILL; cfg_load takes priority over a simultaneous ain_valid (that bit is discarded, yout=0).
REQ-022 yout_q SHALL register yout every cycle.

Reset
REQ-023 While reset=0 the block SHALL hold state IDLE with history, fill, stored pattern, overlap flag and yout_q at 0; yout=0 and busy=0.
REQ-024 Reset asserted mid-sequence SHALL abort any partial match; after release, cfg_load is required before detection resumes.

Configuration
REQ-025 Macro SEQ_DET_MATCH_CNT_EN SHALL, when defined, add input cnt_clr (1) and output match_cnt (CNT_W), reset to 0.
REQ-026 With the macro defined, match_cnt SHALL increment on each yout=1 cycle, saturate at 2^CNT_W-1, and clear on cnt_clr; cnt_clr wins over a simultaneous match; cfg_load does not clear it.
REQ-027 Without the macro, the cnt_clr and match_cnt ports and the counter logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-028 State encodings (IDLE=2'b00, FILL=2'b01, RUN=2'b10) SHALL live in shared package seq_det_pkg as a typedef with named constants.
REQ-029 The saturating counter SHALL be a sub-module sat_counter (parameter W, ports clk, reset, inc, clr, count), instantiated only under SEQ_DET_MATCH_CNT_EN.

Verification
REQ-030 PAT_W=4, pattern 4'b1101, overlap_en=1, stream 1,1,0,1,1,0,1 -> yout=1 on bits 4 and 7 only; yout_q one cycle after each.
REQ-031 Same stream with overlap_en=0 -> yout=1 on bit 4 only; busy high again after bit 4.
REQ-032 Stream 1,1,0 followed by 3 cycles of ain_valid=0, then 1 -> single match, with no loss of history across the gaps.
REQ-033 reset pulled low after 1,1,0, then released with ain=1 and no cfg_load -> yout stays 0 and the state is IDLE.
REQ-034 cfg_load with pattern 4'b0110 in the same cycle as a bit completing 1101 -> yout=0 that cycle; a subsequent 0,1,1,0 -> match.
REQ-035 With SEQ_DET_MATCH_CNT_EN defined and CNT_W=2, five overlapping matches -> match_cnt=3; cnt_clr with a simultaneous match -> match_cnt=0.
